// File: rtl/uart_matrix_ctrl.sv
// UART front end for a matrix engine: collects ELEMS operand bytes, starts the engine,
// then streams RES_BYTES result bytes back out with tx_valid/tx_ready handshaking.
module uart_matrix_ctrl #(
    parameter int ELEMS      = 4,
    parameter int RES_BYTES  = 4,
    parameter int RX_TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    output logic [31:0] mat_data,
    output logic        mat_start,
    input  logic        mat_done,
    input  logic [31:0] mat_result,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  err_cnt
);
    typedef enum logic [2:0] {IDLE, RECV, START, WAIT, SEND} state_t;
    localparam int TW = $clog2(RX_TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [31:0]   mat_data_q, mat_data_d;
    logic [31:0]   res_q, res_d;
    logic          mat_start_q, mat_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          err_inc;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tx_idx_d     = tx_idx_q;
        to_cnt_d     = to_cnt_q;
        mat_data_d   = mat_data_q;
        res_d        = res_q;
        mat_start_d  = 1'b0;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        frame_done_d = 1'b0;
        err_cnt_d    = err_cnt_q;
        err_inc      = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_err) begin
                    err_inc = 1'b1;
                    idx_d   = 3'd0;
                end else if (rx_valid) begin
                    mat_data_d = {24'd0, rx_data};
                    idx_d      = 3'd1;
                    to_cnt_d   = '0;
                    if (ELEMS == 1) begin
                        state_d     = START;
                        mat_start_d = 1'b1;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                // A framing error beats a simultaneous byte strobe: the byte is dropped.
                if (rx_err) begin
                    err_inc  = 1'b1;
                    idx_d    = 3'd0;
                    to_cnt_d = '0;
                    state_d  = IDLE;
                end else if (rx_valid) begin
                    for (int k = 0; k < 4; k++) begin
                        if (idx_q == 3'(k)) mat_data_d[8*k +: 8] = rx_data;
                    end
                    idx_d    = idx_q + 3'd1;
                    to_cnt_d = '0;
                    if (idx_q == 3'(ELEMS - 1)) begin
                        state_d     = START;
                        mat_start_d = 1'b1;
                    end
                end else if (to_cnt_q == TW'(RX_TIMEOUT - 1)) begin
                    err_inc  = 1'b1;
                    idx_d    = 3'd0;
                    to_cnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            START: begin
                err_inc = rx_valid | rx_err;
                idx_d   = 3'd0;
                state_d = WAIT;
            end
            WAIT: begin
                err_inc = rx_valid | rx_err;
                if (mat_done) begin
                    res_d      = mat_result;
                    tx_idx_d   = 3'd0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = mat_result[7:0];
                    state_d    = SEND;
                end
            end
            SEND: begin
                err_inc = rx_valid | rx_err;
                if (tx_valid_q && tx_ready) begin
                    if (tx_idx_q == 3'(RES_BYTES - 1)) begin
                        tx_valid_d   = 1'b0;
                        frame_done_d = 1'b1;
                        tx_idx_d     = 3'd0;
                        state_d      = IDLE;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        for (int k = 0; k < 4; k++) begin
                            if (tx_idx_q + 3'd1 == 3'(k)) tx_data_d = res_q[8*k +: 8];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            tx_idx_q     <= 3'd0;
            to_cnt_q     <= '0;
            mat_data_q   <= 32'd0;
            res_q        <= 32'd0;
            mat_start_q  <= 1'b0;
            tx_data_q    <= 8'd0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tx_idx_q     <= tx_idx_d;
            to_cnt_q     <= to_cnt_d;
            mat_data_q   <= mat_data_d;
            res_q        <= res_d;
            mat_start_q  <= mat_start_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign mat_data   = mat_data_q;
    assign mat_start  = mat_start_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_uart_matrix_ctrl.sv
// Directed bench for uart_matrix_ctrl; expected tx bytes are queued when mat_done is driven
// and popped as the DUT transfers them.
module tb_uart_matrix_ctrl;
    localparam int ELEMS      = 4;
    localparam int RES_BYTES  = 4;
    localparam int RX_TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic [31:0] mat_data;
    logic        mat_start;
    logic        mat_done;
    logic [31:0] mat_result;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;
    logic [7:0]  err_cnt;

    int          errors = 0;
    int          checks = 0;
    int          exp_err = 0;
    int          starts_seen = 0;
    logic [7:0]  exp_q[$];

    uart_matrix_ctrl #(.ELEMS(ELEMS), .RES_BYTES(RES_BYTES), .RX_TIMEOUT(RX_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .mat_data(mat_data), .mat_start(mat_start), .mat_done(mat_done), .mat_result(mat_result),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .frame_done(frame_done), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mat_start === 1'b1) starts_seen <= starts_seen + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] w);
        for (int i = 0; i < ELEMS; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic engine_done(input logic [31:0] r);
        for (int i = 0; i < RES_BYTES; i++) exp_q.push_back(r[8*i +: 8]);
        mat_result = r;
        mat_done   = 1'b1;
        tick();
        mat_done   = 1'b0;
    endtask

    // Drains the scoreboard; stall_at/stall_len hold tx_ready low, stop_after>0 aborts early.
    task automatic collect(input int stall_at, input int stall_len, input int stop_after);
        int n_done = 0;
        int stalled = 0;
        int guard = 0;
        int target;
        target = (stop_after > 0) ? stop_after : RES_BYTES;
        while (n_done < target) begin
            guard++;
            if (guard > 100 || exp_q.size() == 0) begin
                chk("collect_bound", 32'(n_done), 32'(target));
                break;
            end
            chk("tx_valid_high", {31'd0, tx_valid}, 32'd1);
            chk("tx_data", {24'd0, tx_data}, {24'd0, exp_q[0]});
            if (n_done == stall_at && stalled < stall_len) begin
                tx_ready = 1'b0;
                stalled++;
            end else begin
                tx_ready = 1'b1;
                void'(exp_q.pop_front());
                n_done++;
            end
            tick();
        end
        tx_ready = 1'b1;
        if (stop_after == 0) begin
            chk("tx_valid_drop", {31'd0, tx_valid}, 32'd0);
            chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
            chk("busy_after_send", {31'd0, busy}, 32'd0);
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
            tick();
            chk("frame_done_single", {31'd0, frame_done}, 32'd0);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_mat_data", mat_data, 32'd0);
        chk("rst_mat_start", {31'd0, mat_start}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    endtask

    task automatic full_frame(input logic [31:0] ops, input logic [31:0] res, input int stall_at, input int stall_len);
        int s0;
        s0 = starts_seen;
        send_frame(ops);
        $display("frame ops=%h mat_data=%h mat_start=%0d", ops, mat_data, mat_start);
        chk("mat_data", mat_data, ops);
        chk("mat_start_pulse", {31'd0, mat_start}, 32'd1);
        chk("busy_start", {31'd0, busy}, 32'd1);
        tick();
        chk("mat_start_single", {31'd0, mat_start}, 32'd0);
        chk("start_count", 32'(starts_seen), 32'(s0 + 1));
        engine_done(res);
        collect(stall_at, stall_len, 0);
        chk("err_cnt_frame", {24'd0, err_cnt}, 32'(exp_err));
    endtask

    initial begin
        rst = 1'b0; rx_data = 8'd0; rx_valid = 1'b0; rx_err = 1'b0;
        mat_done = 1'b0; mat_result = 32'd0; tx_ready = 1'b1;
        tick(); tick();
        chk_reset_state();
        rst = 1'b1;
        tick();

        full_frame(32'h04030201, 32'h0A0B0C0D, -1, 0);
        full_frame(32'h44332211, 32'h0A0B0C0D, 1, 3);

        // Inter-byte timeout fires exactly RX_TIMEOUT idle cycles after the last byte.
        begin
            int s0;
            s0 = starts_seen;
            send_byte(8'h11);
            send_byte(8'h22);
            repeat (RX_TIMEOUT - 1) tick();
            chk("timeout_not_yet", {31'd0, busy}, 32'd1);
            tick();
            exp_err++;
            $display("timeout busy=%0d err_cnt=%0d", busy, err_cnt);
            chk("timeout_idle", {31'd0, busy}, 32'd0);
            chk("timeout_err", {24'd0, err_cnt}, 32'(exp_err));
            chk("timeout_no_start", 32'(starts_seen), 32'(s0));
        end
        full_frame(32'h08070605, 32'h55667788, -1, 0);

        send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
        rx_err = 1'b1; tick(); rx_err = 1'b0;
        exp_err++;
        $display("rx_err busy=%0d err_cnt=%0d", busy, err_cnt);
        chk("rxerr_idle", {31'd0, busy}, 32'd0);
        chk("rxerr_err", {24'd0, err_cnt}, 32'(exp_err));

        send_byte(8'hAA);
        rx_data = 8'hBB; rx_valid = 1'b1; rx_err = 1'b1;
        tick();
        rx_valid = 1'b0; rx_err = 1'b0;
        exp_err++;
        chk("both_idle", {31'd0, busy}, 32'd0);
        chk("both_err", {24'd0, err_cnt}, 32'(exp_err));

        send_frame(32'hC4C3C2C1);
        chk("clean_mat_data", mat_data, 32'hC4C3C2C1);
        tick();
        send_byte(8'hFF);
        exp_err++;
        $display("overrun in WAIT mat_data=%h err_cnt=%0d", mat_data, err_cnt);
        chk("overrun_err", {24'd0, err_cnt}, 32'(exp_err));
        chk("overrun_mat_data", mat_data, 32'hC4C3C2C1);
        engine_done(32'hDEADBEEF);
        collect(-1, 0, 0);

        mat_result = 32'h01020304; mat_done = 1'b1; tick(); mat_done = 1'b0; tick();
        chk("done_idle_busy", {31'd0, busy}, 32'd0);
        chk("done_idle_txv", {31'd0, tx_valid}, 32'd0);

        send_frame(32'h0F0E0D0C);
        tick();
        engine_done(32'h12345678);
        collect(-1, 0, 2);
        rst = 1'b0; tick(); rst = 1'b1;
        $display("reset mid-SEND tx_valid=%0d busy=%0d err_cnt=%0d", tx_valid, busy, err_cnt);
        chk_reset_state();
        exp_q.delete();
        exp_err = 0;
        full_frame(32'hA4A3A2A1, 32'hB1B2B3B4, -1, 0);

        send_frame(32'h99887766);
        tick();
        repeat (260) begin
            rx_err = 1'b1; tick();
        end
        rx_err = 1'b0;
        exp_err = 255;
        chk("err_saturate", {24'd0, err_cnt}, 32'd255);
        engine_done(32'h13579BDF);
        collect(-1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
